// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the music box tone divider.
// Sequencer and bench convert note frequencies with hz_to_div.
package divisor_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W_DEF  = 24;
  localparam int CLK_HZ     = 25_000_000;

  function automatic logic [DIV_W_DEF-1:0] hz_to_div(
    input int unsigned f
  );
    int unsigned q;
    q = (f == 0) ? 0 : CLK_HZ / (2 * f);
    return q[DIV_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/canal_divisor.sv
// One tone channel: half-period counter with a pending divisor
// that is only applied on a half-period boundary.
module canal_divisor
  import divisor_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_out,
  output logic             o_tick,
  output logic             o_pend
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_act;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_v;
  logic [DIV_W-1:0] r_cnt;
  logic             r_out;
  logic             r_tick;

  logic [DIV_W-1:0] w_act_n;
  logic [DIV_W-1:0] w_pend_n;
  logic             w_pv_n;
  logic [DIV_W-1:0] w_cnt_n;
  logic             w_out_n;
  logic             w_tick_n;
  logic [DIV_W-1:0] w_load;
  logic             w_last;

  assign w_last = (r_cnt == r_act - ONE);
  // A write landing on the boundary itself bypasses pend
  assign w_load = i_wr ? i_div : r_pend;

  always_comb begin
    w_act_n  = r_act;
    w_pend_n = r_pend;
    w_pv_n   = r_pend_v;
    w_cnt_n  = r_cnt;
    w_out_n  = r_out;
    w_tick_n = 1'b0;
    if (i_wr) begin
      w_pend_n = i_div;
      w_pv_n   = 1'b1;
    end
    if (i_en) begin
      if (r_act == '0) begin
        if (r_pend_v) begin
          w_act_n = r_pend;
          w_cnt_n = '0;
          w_out_n = 1'b0;
          if (!i_wr) w_pv_n = 1'b0;
        end
      end else if (w_last) begin
        w_cnt_n = '0;
        if (i_wr || r_pend_v) begin
          w_act_n = w_load;
          w_pv_n  = 1'b0;
        end
        if (w_act_n == '0) begin
          w_out_n = 1'b0;
        end else begin
          w_out_n  = !r_out;
          w_tick_n = !r_out;
        end
      end else begin
        w_cnt_n = r_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_act    <= w_act_n;
      r_pend   <= w_pend_n;
      r_pend_v <= w_pv_n;
      r_cnt    <= w_cnt_n;
      r_out    <= w_out_n;
      r_tick   <= w_tick_n;
    end
  end

  assign o_out  = r_out;
  assign o_tick = r_tick;
  assign o_pend = r_pend_v;

endmodule

// File: rtl/divisor_frecuencia_multi.sv
// Multi-channel square-wave tone divider feeding the voice mixer.
// Decodes the write port into per-channel strobes.
module divisor_frecuencia_multi
  import divisor_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] w_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = wr_en && (wr_ch == CH_W'(i));

    canal_divisor #(
      .DIV_W (DIV_W)
    ) u_canal (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en),
      .i_wr   (w_wr[i]),
      .i_div  (wr_div),
      .o_out  (clk_out[i]),
      .o_tick (tick[i]),
      .o_pend (pending[i])
    );
  end

endmodule

// File: tb/tb_divisor_frecuencia_multi.sv
// Directed bench for the tone divider, 3 channels so that
// wr_ch=3 is an out-of-range write.
module tb_divisor_frecuencia_multi;
  import divisor_pkg::*;

  localparam int NCH = 3;
  localparam int DW  = 24;
  localparam int CW  = 2;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [DW-1:0]  wr_div;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int n_chk;
  int n_err;

  logic [19:0] v_out;
  logic [19:0] v_tick;
  logic [19:0] v_pend;

  divisor_frecuencia_multi #(
    .NUM_CH (NCH),
    .DIV_W  (DW),
    .CH_W   (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [CW-1:0] ch, input logic [DW-1:0] d);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = d;
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;

    chk("hz_to_div", 32'(hz_to_div(3_125_000)), 4);
    #5;
    chk("rst_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pend", 32'(pending), 0);
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    chk("idle_out", 32'(clk_out), 0);

    // ch0 div=4
    wr(0, 4);
    step();
    wr_en = 1'b0;
    chk("s1_pend_set", 32'(pending), 3'b001);
    step();
    chk("s1_pend_clr", 32'(pending), 0);
    chk("s1_out_lo", 32'(clk_out), 0);
    v_out  = '0;
    v_tick = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      v_out[k]  = clk_out[0];
      v_tick[k] = tick[0];
    end
    chk("s1_wave", 32'(v_out[15:0]), 16'h7878);
    chk("s1_tick", 32'(v_tick[15:0]), 16'h0808);

    // ch0 rewrite div=2 at cnt=1
    step();
    wr(0, 2);
    step();
    wr_en = 1'b0;
    chk("s2_pend_set", 32'(pending[0]), 1);
    v_out  = '0;
    v_tick = '0;
    v_pend = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      v_out[k]  = clk_out[0];
      v_tick[k] = tick[0];
      v_pend[k] = pending[0];
    end
    chk("s2_wave", 32'(v_out[7:0]), 8'h66);
    chk("s2_tick", 32'(v_tick[7:0]), 8'h22);
    chk("s2_pend", 32'(v_pend[7:0]), 8'h01);

    // write exactly on the boundary
    step();
    v_out  = '0;
    v_tick = '0;
    v_pend = '0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) wr(0, 3);
      step();
      wr_en     = 1'b0;
      v_out[k]  = clk_out[0];
      v_tick[k] = tick[0];
      v_pend[k] = pending[0];
    end
    chk("s3_wave", 32'(v_out[6:0]), 7'h47);
    chk("s3_tick", 32'(v_tick[6:0]), 7'h41);
    chk("s3_pend", 32'(v_pend[6:0]), 0);

    // ch1 div=3 then silenced
    wr(1, 3);
    step();
    wr_en = 1'b0;
    chk("s4_pend_set", 32'(pending[1]), 1);
    v_out  = '0;
    v_tick = '0;
    v_pend = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      v_out[k]  = clk_out[1];
      v_tick[k] = tick[1];
      v_pend[k] = pending[1];
      if (k == 6) wr(1, 0);
      else wr_en = 1'b0;
    end
    chk("s4_wave", 32'(v_out), 20'h00038);
    chk("s4_tick", 32'(v_tick), 20'h00008);
    chk("s4_pend", 32'(v_pend), 20'h00180);

    // ch2 div=1 with an en-low freeze
    wr(2, 1);
    step();
    wr_en  = 1'b0;
    v_out  = '0;
    v_tick = '0;
    for (int k = 0; k < 11; k++) begin
      step();
      v_out[k]  = clk_out[2];
      v_tick[k] = tick[2];
      if (k == 3) en = 1'b0;
      if (k == 8) en = 1'b1;
    end
    chk("s5_wave", 32'(v_out[10:0]), 11'h5FA);
    chk("s5_tick", 32'(v_tick[10:0]), 11'h40A);

    // out-of-range channel
    wr(3, 5);
    step();
    wr_en = 1'b0;
    chk("s6_oor_pend", 32'(pending), 0);
    repeat (9) step();
    chk("s6_ch1_quiet", 32'(clk_out[1]), 0);
    chk("s6_ch2_phase", 32'(clk_out[2]), 1);
    chk("s6_pend_none", 32'(pending), 0);

    // write lands with en low, then async reset
    en = 1'b0;
    wr(1, 7);
    step();
    wr_en = 1'b0;
    chk("s6_wr_en_low", 32'(pending), 3'b010);
    chk("s6_frozen", 32'(clk_out[2]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_arst_out", 32'(clk_out), 0);
    chk("s6_arst_tick", 32'(tick), 0);
    chk("s6_arst_pend", 32'(pending), 0);
    #5;
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) step();
    chk("s6_post_out", 32'(clk_out), 0);
    chk("s6_post_pend", 32'(pending), 0);
    wr(0, 1);
    step();
    wr_en = 1'b0;
    step();
    step();
    chk("s6_restart_out", 32'(clk_out), 3'b001);
    chk("s6_restart_tick", 32'(tick), 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
